// File: rtl/intra_recon_stream_if.sv
// Block command, residue and reconstructed-row handshakes
// of the intra reconstruction stream.
interface intra_recon_stream_if #(
    parameter int N  = 16,
    parameter int BD = 8
);
    logic                    start;
    logic [1:0]              mode;
    logic                    top_avail;
    logic                    left_avail;
    logic [N*BD-1:0]         toppixels;
    logic [N*BD-1:0]         leftpixels;
    logic                    busy;
    logic                    res_valid;
    logic                    res_ready;
    logic [N*(BD+1)-1:0]     res_row;
    logic                    out_valid;
    logic                    out_ready;
    logic [N*BD-1:0]         out_row;
    logic                    out_last;
    logic                    done;

    modport master (
        output start, mode, top_avail, left_avail,
        output toppixels, leftpixels,
        output res_valid, res_row, out_ready,
        input  busy, res_ready, out_valid,
        input  out_row, out_last, done
    );

    modport slave (
        input  start, mode, top_avail, left_avail,
        input  toppixels, leftpixels,
        input  res_valid, res_row, out_ready,
        output busy, res_ready, out_valid,
        output out_row, out_last, done
    );
endinterface

// File: rtl/intra_recon_stream.sv
// Intra reconstruction: V/H/DC prediction plus residue,
// clipped, streamed one row per handshake.
module intra_recon_stream #(
    parameter int N  = 16,
    parameter int BD = 8
) (
    input logic                 clk,
    input logic                 reset,
    intra_recon_stream_if.slave bus
);
    localparam int LN = $clog2(N);
    localparam int SW = BD + LN;
    localparam logic [BD-1:0] HALF = BD'(1 << (BD - 1));
    localparam logic [BD-1:0] PMAX = '1;
    localparam logic [LN:0]   NR   = (LN + 1)'(N);
    localparam logic [LN:0]   NRL  = (LN + 1)'(N - 1);
    localparam logic [LN-1:0] KL   = LN'(N - 1);

    typedef enum logic [1:0] {IDLE, ACC, ROWS, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_mode;
    logic            r_tav;
    logic            r_lav;
    logic [N*BD-1:0] r_top;
    logic [N*BD-1:0] r_left;
    logic [SW-1:0]   r_sumT;
    logic [SW-1:0]   r_sumL;
    logic [LN-1:0]   r_k;
    logic [BD-1:0]   r_dc;
    logic [LN:0]     r_rin;
    logic            r_ov;
    logic            r_last;
    logic [N*BD-1:0] r_out;

    logic [BD-1:0]   w_top  [N];
    logic [BD-1:0]   w_left [N];
    logic [SW-1:0]   w_sT;
    logic [SW-1:0]   w_sL;
    logic [SW+1:0]   w_tot;
    logic [BD-1:0]   w_dc;
    logic            w_start;
    logic            w_rdy;
    logic            w_acc;
    logic            w_ohs;
    logic [N*BD-1:0] w_rec;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_top[i]  = r_top[i*BD +: BD];
            w_left[i] = r_left[i*BD +: BD];
        end
    end

    assign w_sT = r_sumT + SW'(w_top[r_k]);
    assign w_sL = r_sumL + SW'(w_left[r_k]);

    // Rounded mean over whichever neighbour edges are present
    always_comb begin
        w_tot = '0;
        w_dc  = HALF;
        if (r_tav && r_lav) begin
            w_tot = (SW + 2)'(w_sT) + (SW + 2)'(w_sL)
                  + (SW + 2)'(N);
            w_dc  = BD'(w_tot >> (LN + 1));
        end else if (r_tav) begin
            w_tot = (SW + 2)'(w_sT) + (SW + 2)'(N / 2);
            w_dc  = BD'(w_tot >> LN);
        end else if (r_lav) begin
            w_tot = (SW + 2)'(w_sL) + (SW + 2)'(N / 2);
            w_dc  = BD'(w_tot >> LN);
        end
    end

    assign w_start = (r_state == IDLE) && bus.start;
    assign w_rdy   = (r_state == ROWS)
                   && (!r_ov || bus.out_ready)
                   && (r_rin != NR);
    assign w_acc   = w_rdy && bus.res_valid;
    assign w_ohs   = r_ov && bus.out_ready;

    always_comb begin
        logic [BD-1:0] v_p;
        logic [BD:0]   v_r;
        logic [BD+1:0] v_s;
        v_p   = '0;
        v_r   = '0;
        v_s   = '0;
        w_rec = '0;
        for (int j = 0; j < N; j++) begin
            unique case (r_mode)
                2'd0:    v_p = r_tav ? w_top[j] : HALF;
                2'd1:    v_p = r_lav ? w_left[r_rin[LN-1:0]] : HALF;
                default: v_p = r_dc;
            endcase
            v_r = bus.res_row[j*(BD+1) +: BD+1];
            v_s = {2'b00, v_p} + {v_r[BD], v_r};
            if (v_s[BD+1])
                w_rec[j*BD +: BD] = '0;
            else if (v_s[BD])
                w_rec[j*BD +: BD] = PMAX;
            else
                w_rec[j*BD +: BD] = v_s[BD-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (bus.start) w_next = bus.mode[1] ? ACC : ROWS;
            ACC:  if (r_k == KL) w_next = ROWS;
            ROWS: if (w_ohs && r_last) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= '0;
            r_tav  <= 1'b0;
            r_lav  <= 1'b0;
            r_top  <= '0;
            r_left <= '0;
            r_sumT <= '0;
            r_sumL <= '0;
            r_k    <= '0;
            r_dc   <= '0;
            r_rin  <= '0;
            r_ov   <= 1'b0;
            r_last <= 1'b0;
            r_out  <= '0;
        end else begin
            if (w_start) begin
                r_mode <= bus.mode;
                r_tav  <= bus.top_avail;
                r_lav  <= bus.left_avail;
                r_top  <= bus.toppixels;
                r_left <= bus.leftpixels;
                r_sumT <= '0;
                r_sumL <= '0;
                r_k    <= '0;
                r_rin  <= '0;
            end
            if (r_state == ACC) begin
                r_sumT <= w_sT;
                r_sumL <= w_sL;
                r_k    <= r_k + LN'(1);
                if (r_k == KL)
                    r_dc <= w_dc;
            end
            if (w_acc) begin
                r_out  <= w_rec;
                r_ov   <= 1'b1;
                r_last <= (r_rin == NRL);
                r_rin  <= r_rin + (LN + 1)'(1);
            end else if (w_ohs) begin
                r_ov   <= 1'b0;
                r_last <= 1'b0;
            end
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.res_ready = w_rdy;
    assign bus.out_valid = r_ov;
    assign bus.out_row   = r_out;
    assign bus.out_last  = r_last;
    assign bus.done      = (r_state == DONE);
endmodule

// File: doc/intra_recon_stream.md
# intra_recon_stream

Streaming intra-prediction reconstruction engine for luma blocks of parametrised size. It accepts one block command with neighbouring pixels and a mode, then consumes signed residue one row per handshake. Each output row is `prediction + residue`, clipped to the pixel range. It sits in the intra loop between inverse transform output and the reconstructed-frame writer, and supports back-pressure on both sides.

## Interface
- `N`, 16, block edge in pixels; legal values 4, 8, 16.
- `BD`, 8, pixel bit depth; legal range 8..10.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset; the clock is `clk`, reset is synchronous and active-high.
- `start`  in  1  block command strobe; sampled only in IDLE.
- `mode`  in  2  0 vertical, 1 horizontal, 2 DC, 3 treated as DC.
- `top_avail`  in  1  top neighbours valid.
- `left_avail`  in  1  left neighbours valid.
- `toppixels`  in  N*BD  top row, pixel i at bits [i*BD +: BD].
- `leftpixels`  in  N*BD  left column, pixel i at bits [i*BD +: BD].
- `busy`  out  1  high from start acceptance until the done cycle inclusive.
- `res_valid`  in  1  residue row valid.
- `res_ready`  out  1  residue row accepted when `res_valid` and `res_ready` are both high.
- `res_row`  in  N*(BD+1)  signed two's-complement residues, pixel j at [j*(BD+1) +: BD+1].
- `out_valid`  out  1  reconstructed row valid.
- `out_ready`  in  1  downstream accepts the row.
- `out_row`  out  N*BD  reconstructed row, same packing as `toppixels`.
- `out_last`  out  1  qualifies row N-1 while `out_valid` is high.
- `done`  out  1  one-cycle pulse after row N-1 is handshaken.

## Operation
- FSM states: IDLE, ACC, ROWS, DONE.
- IDLE: on `start`, latch `mode`, availability flags and both neighbour vectors, then set `busy`. DC modes go to ACC; modes 0 and 1 go to ROWS.
- ACC: lasts N cycles. Cycle k adds top[k] and left[k] into sum registers `sumT` and `sumL`, each BD+log2(N) bits wide. After cycle N-1, the DC value is registered and the FSM moves to ROWS.
- DC value:
  - both neighbours available: (sumT + sumL + N) >> log2(2N)
  - top only: (sumT + N/2) >> log2(N)
  - left only: (sumL + N/2) >> log2(N)
  - neither: 1 << (BD-1)
- Vertical: pred[r][j] = top[j]. If top is unavailable, every pred is 1<<(BD-1).
- Horizontal: pred[r][j] = left[r]. If left is unavailable, every pred is 1<<(BD-1).
- ROWS: row counter r runs 0..N-1. Each accepted residue row produces out_row[j] = clip(pred[r][j] + res[j], 0, 2^BD-1). The sum is computed in BD+2 signed bits.
- The output stage is a single register. `res_ready` = (state==ROWS) and (!out_valid or out_ready) and no residue row beyond N-1 has been accepted.
- When row N-1 is handshaken on the output, the FSM moves to DONE. DONE pulses `done`, then returns to IDLE.
- `start` is ignored while `busy` is high. Residue presented outside ROWS is not accepted.

## Timing
- Reset values: state IDLE, counters 0, `busy` 0, `res_ready` 0, `out_valid` 0, `out_row` 0, `out_last` 0, `done` 0.
- Reset mid-block aborts immediately: no `done` pulse, and the row in flight is discarded.
- `start` latency: ROWS is entered 1 cycle after `start` for V/H, and N+1 cycles after `start` for DC.
- A residue row handshaken in cycle t appears on `out_row` with `out_valid` high in cycle t+1.
- While out_valid=1 and out_ready=0, `out_row` and `out_last` hold stable and `res_ready` is 0.
- Simultaneous output handshake and new residue acceptance in the same cycle is allowed, giving full throughput of 1 row/cycle.
- `done` is asserted the cycle after the output handshake of row N-1. `busy` falls the cycle after `done`.
- Minimum block time with no stalls: N+2 cycles for V/H, 2N+2 cycles for DC.

## Test plan
- Vertical, N=4, BD=8, top=10,20,30,40, zero residue: 4 rows of 10,20,30,40. `out_last` high only on row 3. `done` pulses once.
- DC, N=4, both neighbours available, top all 100, left all 101: (400+404+4)>>3 = 101, so every pixel is 101. The first row-acceptance opportunity comes 5 cycles after `start`.
- DC availability cases, N=4: top-only with top=1,2,3,4 gives (10+2)>>2 = 3. Neither available gives 128.
- Clipping, horizontal, N=4:
  - left[0]=250 with residue +10 gives 255.
  - left[1]=5 with residue −10 gives 0.
  - residue −256 on pred 0 gives 0.
- Back-pressure: hold `out_ready` low for 3 cycles at row 1. `out_row` stays stable and `res_ready` stays 0. All 4 rows arrive in order with none lost or duplicated. A `start` pulsed during the block is ignored.
- Reset mid-block: assert `reset` during row 2. The next cycle shows `out_valid`=0 and `busy`=0, and `done` never pulses. A fresh vertical command afterwards completes correctly.
